uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `tx_uart` transmitter between `NUM_REQ` byte-stream requesters (e.g. CPU console, debug monitor, boot loader). It latches the granted byte and drives the `tx_uart` `valid`/`tx_data` inputs, then returns the transmitter's one-cycle `ready` completion pulse to the owning requester. The grant is locked for a whole message: it is held until the requester marks a byte `last`, or until an idle timeout expires, so messages from different requesters never interleave on the line.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_SEND = 2'd1,
      ARB_LOCK = 2'd2
   } arb_state_t;

   // Increment with explicit wrap so non-power-of-two requester counts work.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotated priority encoder: first asserted request at or above ptr, wrapping.
module uart_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               hit,
   output logic [IDX_W-1:0]   idx
);

   function automatic int rot(input int k);
      int s;
      s = int'(ptr) + k;
      return (s >= NUM_REQ) ? s - NUM_REQ : s;
   endfunction

   // Scanning offsets from highest to lowest lets the closest hit win.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (req[j] && (j == rot(k))) begin
               hit = 1'b1;
               idx = IDX_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking arbiter sharing one tx_uart between requesters.
//   state    | meaning
//   ARB_IDLE | no owner; search requests from rr_ptr upward
//   ARB_SEND | latched byte on uart_valid/uart_data, waiting for uart_ready
//   ARB_LOCK | message open; only the owner may send, idle timer running
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int LOCK_TIMEOUT = 1024,
   parameter int IDX_W        = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]             req_last,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           uart_valid,
   output logic [UART_DATA_W-1:0]         uart_data,
   input  logic                           uart_ready,
   output logic [IDX_W-1:0]               grant_idx,
   output logic                           locked
);

   localparam int TMR_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = (LOCK_TIMEOUT > 0) ? TMR_W'(LOCK_TIMEOUT - 1) : '0;

   arb_state_t             state_q, state_d;
   logic                   uart_valid_q, uart_valid_d;
   logic [UART_DATA_W-1:0] data_q, data_d;
   logic                   last_q, last_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic                   locked_q, locked_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;

   logic                   pick_hit;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W-1:0]       sel;
   logic [UART_DATA_W-1:0] sel_data;
   logic                   sel_last;
   logic                   owner_valid;
   logic [IDX_W-1:0]       ptr_after_owner;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .hit (pick_hit),
      .idx (pick_idx)
   );

   assign sel             = (state_q == ARB_LOCK) ? grant_q : pick_idx;
   assign ptr_after_owner = IDX_W'(wrap_inc(int'(grant_q), NUM_REQ));

   always_comb begin
      sel_data    = '0;
      sel_last    = 1'b0;
      owner_valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == sel) begin
            sel_data = req_data[i*UART_DATA_W +: UART_DATA_W];
            sel_last = req_last[i];
         end
         if (IDX_W'(i) == grant_q) begin
            owner_valid = req_valid[i];
         end
      end
   end

   // Completion is returned in the same cycle the transmitter reports it.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = (state_q == ARB_SEND) && uart_ready && (IDX_W'(i) == grant_q);
      end
   end

   always_comb begin
      state_d      = state_q;
      uart_valid_d = uart_valid_q;
      data_d       = data_q;
      last_d       = last_q;
      grant_d      = grant_q;
      locked_d     = locked_q;
      rr_ptr_d     = rr_ptr_q;
      tmr_d        = tmr_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_hit) begin
               data_d       = sel_data;
               last_d       = sel_last;
               grant_d      = pick_idx;
               uart_valid_d = 1'b1;
               state_d      = ARB_SEND;
            end
         end
         ARB_SEND: begin
            if (uart_ready) begin
               uart_valid_d = 1'b0;
               if (last_q || (LOCK_TIMEOUT == 0)) begin
                  rr_ptr_d = ptr_after_owner;
                  locked_d = 1'b0;
                  state_d  = ARB_IDLE;
               end else begin
                  locked_d = 1'b1;
                  tmr_d    = TMR_LOAD;
                  state_d  = ARB_LOCK;
               end
            end
         end
         ARB_LOCK: begin
            // The owner's byte takes priority over an expiring timer.
            if (owner_valid) begin
               data_d       = sel_data;
               last_d       = sel_last;
               uart_valid_d = 1'b1;
               state_d      = ARB_SEND;
            end else if (tmr_q <= TMR_W'(1)) begin
               locked_d = 1'b0;
               rr_ptr_d = ptr_after_owner;
               state_d  = ARB_IDLE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: begin
            uart_valid_d = 1'b0;
            locked_d     = 1'b0;
            state_d      = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ARB_IDLE;
         uart_valid_q <= 1'b0;
         data_q       <= '0;
         last_q       <= 1'b0;
         grant_q      <= '0;
         locked_q     <= 1'b0;
         rr_ptr_q     <= '0;
         tmr_q        <= '0;
      end else begin
         state_q      <= state_d;
         uart_valid_q <= uart_valid_d;
         data_q       <= data_d;
         last_q       <= last_d;
         grant_q      <= grant_d;
         locked_q     <= locked_d;
         rr_ptr_q     <= rr_ptr_d;
         tmr_q        <= tmr_d;
      end
   end

   assign uart_valid = uart_valid_q;
   assign uart_data  = data_q;
   assign grant_idx  = grant_q;
   assign locked     = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a tx_uart model and a message-level reference model.
module tb_uart_tx_arbiter;

   localparam int NR     = 3;
   localparam int LT     = 16;
   localparam int IW     = 2;
   localparam int TX_CYC = 3;
   localparam int QD     = 256;

   logic            clk = 1'b0;
   logic            resetn;
   logic [NR-1:0]   req_valid;
   logic [NR*8-1:0] req_data;
   logic [NR-1:0]   req_last;
   logic [NR-1:0]   req_ready;
   logic            uart_valid;
   logic [7:0]      uart_data;
   logic            uart_ready;
   logic [IW-1:0]   grant_idx;
   logic            locked;

   uart_tx_arbiter #(
      .NUM_REQ      (NR),
      .LOCK_TIMEOUT (LT)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .uart_valid (uart_valid),
      .uart_data  (uart_data),
      .uart_ready (uart_ready),
      .grant_idx  (grant_idx),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [8:0] rmem [NR][QD];
   int         rhead [NR];
   int         rtail [NR];
   int         log_n;
   logic [7:0] log_dat [QD];
   int         log_who [QD];
   int         exp_n;
   logic [7:0] exp_dat [QD];
   int         exp_who [QD];
   int         m_ptr;

   logic       tx_busy, tx_wait_low, tx_stable_ok;
   logic [7:0] tx_byte;
   int         tx_cnt;

   typedef struct {
      logic [2:0] mask;
      logic [7:0] d0, d1, d2;
      int         cnt;
      int         s0, s1, s2;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic bit q_empty();
      for (int i = 0; i < NR; i++) if (rhead[i] < rtail[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clear_q();
      for (int i = 0; i < NR; i++) begin
         rhead[i] = 0;
         rtail[i] = 0;
      end
   endtask

   task automatic push(input int i, input logic [7:0] d, input logic last);
      rmem[i][rtail[i]] = {last, d};
      rtail[i]++;
   endtask

   task automatic add_exp(input int who, input logic [7:0] d);
      exp_who[exp_n] = who;
      exp_dat[exp_n] = d;
      exp_n++;
   endtask

   // Message-level model: whole messages in round-robin order; a message ends at a
   // last byte, or when the owner runs dry (lock timeout). Pointer moves past the owner.
   task automatic model_expect();
      int  h [NR];
      int  own;
      bit  found;
      bit  last;
      for (int i = 0; i < NR; i++) h[i] = rhead[i];
      forever begin
         found = 1'b0;
         own   = 0;
         for (int k = 0; k < NR; k++) begin
            if (!found && h[(m_ptr + k) % NR] < rtail[(m_ptr + k) % NR]) begin
               found = 1'b1;
               own   = (m_ptr + k) % NR;
            end
         end
         if (!found) break;
         do begin
            add_exp(own, rmem[own][h[own]][7:0]);
            last = rmem[own][h[own]][8];
            h[own]++;
         end while (!last && h[own] < rtail[own]);
         m_ptr = (own + 1) % NR;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      clear_q();
      log_n = 0;
      exp_n = 0;
      m_ptr = 0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!uart_ready && n < 200);
      chk({name, "_ready_seen"}, 32'(uart_ready), 32'd1);
   endtask

   task automatic wait_quiet(input string name);
      int n;
      bit quiet;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         quiet = !uart_valid && !locked && !tx_busy && !tx_wait_low && q_empty();
      end while (!quiet && n < 3000);
      checks++;
      if (!quiet) begin
         errors++;
         $display("FAIL %s_drain: not idle after %0d cycles, required idle", name, n);
      end
   endtask

   task automatic compare_log(input string name);
      chk({name, "_count"}, 32'(log_n), 32'(exp_n));
      for (int k = 0; k < exp_n && k < log_n; k++) begin
         checks++;
         if (log_who[k] != exp_who[k] || log_dat[k] != exp_dat[k]) begin
            errors++;
            $display("FAIL %s_byte%0d: got req%0d/%02h, expected req%0d/%02h",
                     name, k, log_who[k], log_dat[k], exp_who[k], exp_dat[k]);
         end
      end
   endtask

   // Requesters: present queue heads, pop on req_ready, next byte from m+1.
   initial begin : drv
      logic [NR-1:0] pop;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         pop = '0;
         if (uart_ready) begin
            int who;
            who = -1;
            for (int i = 0; i < NR; i++) if (req_ready[i]) who = i;
            checks++;
            if (!$onehot(req_ready)) begin
               errors++;
               $display("FAIL ready_onehot: req_ready=%b, required one-hot", req_ready);
            end else if (rhead[who] >= rtail[who]) begin
               errors++;
               $display("FAIL ready_owner: req_ready=%b for requester with nothing pending", req_ready);
            end else begin
               pop[who] = 1'b1;
               if (rmem[who][rhead[who]][7:0] != uart_data) begin
                  errors++;
                  $display("FAIL ready_data: line %02h, required req%0d byte %02h",
                           uart_data, who, rmem[who][rhead[who]][7:0]);
               end
            end
            if (log_n < QD) begin
               log_dat[log_n] = uart_data;
               log_who[log_n] = who;
               log_n++;
            end
         end else if (req_ready != '0) begin
            checks++;
            errors++;
            $display("FAIL ready_stray: req_ready=%b without uart_ready, required 0", req_ready);
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++) if (pop[i]) rhead[i]++;
         for (int i = 0; i < NR; i++) begin
            if (rhead[i] < rtail[i]) begin
               req_valid[i]        = 1'b1;
               req_data[i*8 +: 8]  = rmem[i][rhead[i]][7:0];
               req_last[i]         = rmem[i][rhead[i]][8];
            end else begin
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
            end
         end
      end
   end

   // tx_uart model: accepts on uart_valid, pulses ready after a few cycles, needs valid low to re-arm.
   initial begin : txm
      uart_ready   = 1'b0;
      tx_busy      = 1'b0;
      tx_wait_low  = 1'b0;
      tx_stable_ok = 1'b1;
      tx_byte      = '0;
      tx_cnt       = 0;
      forever begin
         @(posedge clk);
         #1;
         uart_ready = 1'b0;
         if (!resetn) begin
            tx_busy     = 1'b0;
            tx_wait_low = 1'b0;
         end else if (tx_busy) begin
            if (!uart_valid || uart_data != tx_byte) tx_stable_ok = 1'b0;
            if (tx_cnt == 0) begin
               checks++;
               if (!tx_stable_ok) begin
                  errors++;
                  $display("FAIL data_stable: byte %02h changed or valid dropped during send", tx_byte);
               end
               uart_ready  = 1'b1;
               tx_busy     = 1'b0;
               tx_wait_low = 1'b1;
            end else begin
               tx_cnt--;
            end
         end else if (tx_wait_low) begin
            checks++;
            if (uart_valid) begin
               errors++;
               $display("FAIL gap: uart_valid=1 the cycle after completion, required 0");
            end
            tx_wait_low = 1'b0;
         end else if (uart_valid) begin
            tx_busy      = 1'b1;
            tx_byte      = uart_data;
            tx_cnt       = TX_CYC;
            tx_stable_ok = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n;
      logic [7:0] d [NR];
      int         s [3];

      tbl[0] = '{3'b011, 8'h30, 8'h31, 8'h32, 2, 0, 1, 0};
      tbl[1] = '{3'b011, 8'h30, 8'h31, 8'h32, 2, 0, 1, 0};
      tbl[2] = '{3'b111, 8'hA0, 8'hA1, 8'hA2, 3, 2, 0, 1};
      tbl[3] = '{3'b110, 8'hB0, 8'hB1, 8'hB2, 2, 2, 1, 0};
      tbl[4] = '{3'b001, 8'hC0, 8'hC1, 8'hC2, 1, 0, 0, 0};
      tbl[5] = '{3'b101, 8'hD0, 8'hD1, 8'hD2, 2, 2, 0, 0};
      tbl[6] = '{3'b111, 8'hE0, 8'hE1, 8'hE2, 3, 1, 2, 0};
      tbl[7] = '{3'b010, 8'hF0, 8'hF1, 8'hF2, 1, 1, 0, 0};

      resetn = 1'b0;
      clear_q();
      log_n = 0;
      exp_n = 0;
      m_ptr = 0;
      repeat (2) @(negedge clk);
      chk("rst_uart_valid", 32'(uart_valid), 32'd0);
      chk("rst_uart_data",  32'(uart_data),  32'd0);
      chk("rst_req_ready",  32'(req_ready),  32'd0);
      chk("rst_grant_idx",  32'(grant_idx),  32'd0);
      chk("rst_locked",     32'(locked),     32'd0);
      resetn = 1'b1;

      // Single byte: grant latency, completion, no lock.
      do_reset();
      push(0, 8'h41, 1'b1);
      add_exp(0, 8'h41);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_valid[0] && n < 20);
      chk("t1_valid_before", 32'(uart_valid), 32'd0);
      @(negedge clk);
      chk("t1_grant_latency", 32'(uart_valid), 32'd1);
      chk("t1_data", 32'(uart_data), 32'h41);
      wait_ready("t1");
      chk("t1_locked_at_done", 32'(locked), 32'd0);
      @(negedge clk);
      chk("t1_locked_after", 32'(locked), 32'd0);
      wait_quiet("t1");
      compare_log("t1");

      // Table-driven round-robin bursts of single-byte messages.
      do_reset();
      for (int v = 0; v < 8; v++) begin
         clear_q();
         log_n = 0;
         exp_n = 0;
         d[0] = tbl[v].d0;
         d[1] = tbl[v].d1;
         d[2] = tbl[v].d2;
         s[0] = tbl[v].s0;
         s[1] = tbl[v].s1;
         s[2] = tbl[v].s2;
         for (int i = 0; i < NR; i++) if (tbl[v].mask[i]) push(i, d[i], 1'b1);
         for (int k = 0; k < tbl[v].cnt; k++) add_exp(s[k], d[s[k]]);
         wait_quiet($sformatf("vec%0d", v));
         compare_log($sformatf("vec%0d", v));
      end

      // Message lock: "ABC" from req0 while req1 waits.
      do_reset();
      push(0, 8'h41, 1'b0);
      push(0, 8'h42, 1'b0);
      push(0, 8'h43, 1'b1);
      push(1, 8'h5A, 1'b1);
      add_exp(0, 8'h41);
      add_exp(0, 8'h42);
      add_exp(0, 8'h43);
      add_exp(1, 8'h5A);
      wait_ready("t3a");
      @(negedge clk);
      chk("t3_locked_after_A", 32'(locked), 32'd1);
      chk("t3_grant_after_A", 32'(grant_idx), 32'd0);
      wait_ready("t3b");
      wait_ready("t3c");
      @(negedge clk);
      chk("t3_unlocked_after_C", 32'(locked), 32'd0);
      wait_quiet("t3");
      compare_log("t3");

      // Lock timeout: exactly LT cycles after completion, then req1.
      do_reset();
      push(0, 8'h11, 1'b0);
      push(1, 8'h22, 1'b1);
      add_exp(0, 8'h11);
      add_exp(1, 8'h22);
      wait_ready("t4");
      repeat (LT - 1) @(negedge clk);
      chk("t4_locked_before_expiry", 32'(locked), 32'd1);
      chk("t4_other_ignored", 32'(uart_valid), 32'd0);
      @(negedge clk);
      chk("t4_unlocked_at_expiry", 32'(locked), 32'd0);
      @(negedge clk);
      chk("t4_req1_valid", 32'(uart_valid), 32'd1);
      chk("t4_req1_data", 32'(uart_data), 32'h22);
      wait_quiet("t4");
      compare_log("t4");

      // Wrap-around with three continuously valid requesters.
      do_reset();
      push(0, 8'h01, 1'b1);
      push(0, 8'h02, 1'b1);
      push(1, 8'h11, 1'b1);
      push(1, 8'h12, 1'b1);
      push(2, 8'h21, 1'b1);
      add_exp(0, 8'h01);
      add_exp(1, 8'h11);
      add_exp(2, 8'h21);
      add_exp(0, 8'h02);
      add_exp(1, 8'h12);
      wait_quiet("t5");
      compare_log("t5");

      // Reset in the middle of a byte.
      do_reset();
      push(2, 8'h77, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!uart_valid && n < 50);
      chk("t6_sending", 32'(uart_valid), 32'd1);
      chk("t6_grant", 32'(grant_idx), 32'd2);
      @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      chk("t6_rst_uart_valid", 32'(uart_valid), 32'd0);
      chk("t6_rst_uart_data",  32'(uart_data),  32'd0);
      chk("t6_rst_grant",      32'(grant_idx),  32'd0);
      chk("t6_rst_locked",     32'(locked),     32'd0);
      chk("t6_rst_req_ready",  32'(req_ready),  32'd0);
      clear_q();
      log_n = 0;
      exp_n = 0;
      m_ptr = 0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      push(1, 8'h66, 1'b1);
      add_exp(1, 8'h66);
      wait_quiet("t6");
      compare_log("t6");

      // Random message mixes against the message-level model.
      do_reset();
      for (int r = 0; r < 20; r++) begin
         clear_q();
         log_n = 0;
         exp_n = 0;
         for (int i = 0; i < NR; i++) begin
            int len;
            len = $urandom_range(0, 4);
            for (int j = 0; j < len; j++) push(i, 8'($urandom), 1'($urandom_range(0, 1)));
         end
         model_expect();
         wait_quiet($sformatf("rnd%0d", r));
         compare_log($sformatf("rnd%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
